// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: walks one active-low column per scan tick, debounces
// press and release, strobes each accepted key and shifts it into number_out.
module hex_keypad_scanner #(
    parameter int SCAN_DIV_W     = 18,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  in_row,
    input  logic        clear,
    output logic [3:0]  out_col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [31:0] number_out
);
    // state    | meaning
    // SCAN     | rotating columns, waiting for exactly one row low
    // DEBOUNCE | row seen low, counting consecutive stable ticks
    // RELEASE  | key accepted, counting consecutive all-released ticks
    typedef enum logic [1:0] {SCAN, DEBOUNCE, RELEASE} state_t;

    localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

    logic [3:0]            row_meta_q, row_sync_q;
    logic [SCAN_DIV_W-1:0] psc_q;
    logic                  tick;
    state_t                state_q, state_d;
    logic [1:0]            col_q, col_d;
    logic [3:0]            cnt_q, cnt_d, cnt_inc;
    logic [3:0]            row_pat_q, row_pat_d;
    logic                  key_valid_q, key_valid_d;
    logic [3:0]            key_code_q, key_code_d, code;
    logic [31:0]           number_q, number_d;
    logic                  one_low, accept;
    logic [1:0]            row_idx;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            psc_q       <= '0;
            state_q     <= SCAN;
            col_q       <= 2'd0;
            cnt_q       <= 4'd0;
            row_pat_q   <= 4'hF;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            number_q    <= 32'h0;
        end else begin
            row_meta_q  <= in_row;
            row_sync_q  <= row_meta_q;
            psc_q       <= psc_q + 1'b1;
            state_q     <= state_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            row_pat_q   <= row_pat_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            number_q    <= number_d;
        end
    end

    assign tick    = &psc_q;
    assign one_low = $onehot(~row_sync_q);
    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
        row_idx = 2'd3;
        if (!row_sync_q[0])      row_idx = 2'd0;
        else if (!row_sync_q[1]) row_idx = 2'd1;
        else if (!row_sync_q[2]) row_idx = 2'd2;
    end

    always_comb begin
        code = 4'h0;
        case ({row_idx, col_q})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;
            4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;
            4'b11_11: code = 4'hD;
            default:  code = 4'h0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        row_pat_d   = row_pat_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        number_d    = number_q;
        accept      = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (one_low) begin
                        row_pat_d = row_sync_q;
                        if (DB_N == 4'd1) begin
                            accept  = 1'b1;
                            cnt_d   = 4'd0;
                            state_d = RELEASE;
                        end else begin
                            cnt_d   = 4'd1;
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (row_sync_q == row_pat_q) begin
                        if (cnt_inc == DB_N) begin
                            accept  = 1'b1;
                            cnt_d   = 4'd0;
                            state_d = RELEASE;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d   = 4'd0;
                        col_d   = col_q + 2'd1;
                        state_d = SCAN;
                    end
                end
                RELEASE: begin
                    if (row_sync_q == 4'hF) begin
                        if (cnt_inc == DB_N) begin
                            cnt_d   = 4'd0;
                            col_d   = 2'd0;
                            state_d = SCAN;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
        // Accept always happens with the stable row on rs, so decode straight from it.
        if (accept) begin
            key_valid_d = 1'b1;
            key_code_d  = code;
            number_d    = {number_q[27:0], code};
        end
        if (clear) number_d = 32'h0;
    end

    assign out_col    = ~(4'b0001 << col_q);
    assign key_valid  = key_valid_q;
    assign key_code   = key_code_q;
    assign number_out = number_q;
endmodule
